// File: rtl/riscv32b_bus_pkg.sv
// riscv32b_bus_pkg: shared bus types for the data-memory arbiter.
package riscv32b_bus_pkg;
    localparam int RGN_RAM = 0;
    localparam int RGN_PER = 1;
    typedef enum logic {M0 = 1'b0, M1 = 1'b1} mst_t;
    typedef enum logic [1:0] {SRC_RAM = 2'd0, SRC_PER = 2'd1, SRC_ERR = 2'd2} src_t;
endpackage

// File: rtl/bus_rr_arb2.sv
// bus_rr_arb2: two-way round-robin arbiter with M1 bus lock.
module bus_rr_arb2
    import riscv32b_bus_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic req0,
    input  logic req1,
    input  logic lock,
    output logic gnt0,
    output logic gnt1,
    output mst_t rr_last
);
    mst_t rr_last_q, rr_last_d;
    logic elig0;
    always_comb begin
        // grants are masked during reset so nothing reaches the memories
        elig0     = rstn & req0 & ~(lock & (rr_last_q == M1));
        gnt0      = elig0 & (~req1 | (rr_last_q == M1));
        gnt1      = rstn & req1 & ~gnt0;
        rr_last_d = gnt0 ? M0 : gnt1 ? M1 : rr_last_q;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rr_last_q <= M1;
        else       rr_last_q <= rr_last_d;
    end
    assign rr_last = rr_last_q;
endmodule

// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter: shares data RAM and peripheral window between CPU (M0) and loader (M1).
module dmem_bus_arbiter
    import riscv32b_bus_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RGN_LSB = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic          ram_en,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          per_en,
    output logic          per_wr,
    output logic [AW-1:0] per_addr,
    output logic [DW-1:0] per_wdata,
    input  logic [DW-1:0] per_rdata
);
    localparam int RW = AW - RGN_LSB;

    mst_t          rr_last;
    logic          any_gnt, wr, hit_ram, hit_per;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rsp_data;
    logic [RW-1:0] rgn;
    logic          rsp_q, rsp_d, rd_q, rd_d;
    mst_t          owner_q, owner_d;
    src_t          src_q, src_d;

    bus_rr_arb2 u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req0    (m0_req),
        .req1    (m1_req),
        .lock    (m1_lock),
        .gnt0    (m0_gnt),
        .gnt1    (m1_gnt),
        .rr_last (rr_last)
    );

    always_comb begin
        any_gnt   = m0_gnt | m1_gnt;
        addr      = m1_gnt ? m1_addr : m0_addr;
        wr        = m1_gnt ? m1_wr : m0_wr;
        wdata     = m1_gnt ? m1_wdata : m0_wdata;
        rgn       = addr[AW-1:RGN_LSB];
        hit_ram   = rgn == RW'(RGN_RAM);
        hit_per   = rgn == RW'(RGN_PER);
        ram_en    = any_gnt & hit_ram;
        ram_wr    = ram_en & wr;
        ram_addr  = ram_en ? addr : '0;
        ram_wdata = ram_en ? wdata : '0;
        per_en    = any_gnt & hit_per;
        per_wr    = per_en & wr;
        per_addr  = per_en ? addr : '0;
        per_wdata = per_en ? wdata : '0;
        // a response is owed for every read and for any unmapped access
        rsp_d     = any_gnt & (~wr | ~(hit_ram | hit_per));
        rd_d      = ~wr;
        owner_d   = m1_gnt ? M1 : M0;
        src_d     = hit_ram ? SRC_RAM : hit_per ? SRC_PER : SRC_ERR;
        rsp_data  = (src_q == SRC_RAM) ? ram_rdata : (src_q == SRC_PER) ? per_rdata : '0;
        m0_rvalid = rsp_q & rd_q & (owner_q == M0);
        m1_rvalid = rsp_q & rd_q & (owner_q == M1);
        m0_err    = rsp_q & (src_q == SRC_ERR) & (owner_q == M0);
        m1_err    = rsp_q & (src_q == SRC_ERR) & (owner_q == M1);
        m0_rdata  = m0_rvalid ? rsp_data : '0;
        m1_rdata  = m1_rvalid ? rsp_data : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_q   <= 1'b0;
            rd_q    <= 1'b0;
            owner_q <= M0;
            src_q   <= SRC_RAM;
        end else begin
            rsp_q   <= rsp_d;
            rd_q    <= rd_d;
            owner_q <= owner_d;
            src_q   <= src_d;
        end
    end
endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb_dmem_bus_arbiter: table-driven cycle vectors plus reset corner sequences.
module tb_dmem_bus_arbiter;
    localparam logic [31:0] M0WD = 32'hA5A5_0000;
    localparam logic [31:0] M1WD = 32'h5A5A_0000;

    typedef struct {
        logic r0, w0; logic [31:0] a0;
        logic r1, w1; logic [31:0] a1;
        logic lk; logic [31:0] rram, rper;
        logic g0, g1, ren, pen, ew; logic [31:0] eaddr;
        logic v0, e0; logic [31:0] d0;
        logic v1, e1; logic [31:0] d1;
    } vec_t;
    typedef logic [168:0] obs_t;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0, m1_lock = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = M0WD, m1_wdata = M1WD;
    logic [31:0] ram_rdata = 0, per_rdata = 0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en, ram_wr, per_en, per_wr;
    logic [31:0] ram_addr, ram_wdata, per_addr, per_wdata;
    int          errors = 0, checks = 0;
    vec_t        tbl [25];

    dmem_bus_arbiter dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .per_en(per_en), .per_wr(per_wr), .per_addr(per_addr), .per_wdata(per_wdata),
        .per_rdata(per_rdata)
    );

    always #5 clk = ~clk;

    function automatic obs_t actual();
        logic        w;
        logic [31:0] a, d;
        w = ram_en ? ram_wr : per_en ? per_wr : 1'b0;
        a = ram_en ? ram_addr : per_en ? per_addr : 32'h0;
        d = ram_en ? ram_wdata : per_en ? per_wdata : 32'h0;
        return {m0_gnt, m1_gnt, ram_en, per_en, w, a, d,
                m0_rvalid, m0_err, m0_rdata, m1_rvalid, m1_err, m1_rdata};
    endfunction

    function automatic obs_t expect_of(vec_t v);
        logic [31:0] d;
        d = (v.ren | v.pen) ? (v.g1 ? M1WD : M0WD) : 32'h0;
        return {v.g0, v.g1, v.ren, v.pen, v.ew, v.eaddr, d,
                v.v0, v.e0, v.d0, v.v1, v.e1, v.d1};
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t got;
        got = actual();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        m0_req = v.r0; m0_wr = v.w0; m0_addr = v.a0;
        m1_req = v.r1; m1_wr = v.w1; m1_addr = v.a1;
        m1_lock = v.lk; ram_rdata = v.rram; per_rdata = v.rper;
    endtask

    function automatic vec_t mk(input logic r0, w0, input logic [31:0] a0,
                                input logic r1, w1, input logic [31:0] a1, input logic lk,
                                input logic [31:0] rram, rper,
                                input logic g0, g1, ren, pen, ew, input logic [31:0] eaddr,
                                input logic v0, e0, input logic [31:0] d0,
                                input logic v1, e1, input logic [31:0] d1);
        vec_t v;
        v = '{r0, w0, a0, r1, w1, a1, lk, rram, rper, g0, g1, ren, pen, ew, eaddr, v0, e0, d0, v1, e1, d1};
        return v;
    endfunction

    initial begin
        vec_t v;
        //           r0 w0 a0            r1 w1 a1            lk rram           rper          g0 g1 re pe ew addr        v0 e0 d0             v1 e1 d1
        tbl[0]  = mk(1, 0, 32'h0,        1, 0, 32'h4,        0, 32'h0,         32'h0,        1, 0, 1, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 32'h0);
        tbl[1]  = mk(1, 0, 32'h0,        1, 0, 32'h4,        0, 32'hA0A0_0001, 32'h0,        0, 1, 1, 0, 0, 32'h4,      1, 0, 32'hA0A0_0001, 0, 0, 32'h0);
        tbl[2]  = mk(1, 0, 32'h0,        1, 0, 32'h4,        0, 32'hB0B0_0002, 32'h0,        1, 0, 1, 0, 0, 32'h0,      0, 0, 32'h0,         1, 0, 32'hB0B0_0002);
        tbl[3]  = mk(1, 0, 32'h0,        1, 0, 32'h4,        0, 32'hC0C0_0003, 32'h0,        0, 1, 1, 0, 0, 32'h4,      1, 0, 32'hC0C0_0003, 0, 0, 32'h0);
        tbl[4]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hD0D0_0004, 32'h0,        0, 0, 0, 0, 0, 32'h0,      0, 0, 32'h0,         1, 0, 32'hD0D0_0004);
        tbl[5]  = mk(1, 0, 32'h10,       0, 0, 32'h0,        0, 32'h0,         32'h0,        1, 0, 1, 0, 0, 32'h10,     0, 0, 32'h0,         0, 0, 32'h0);
        tbl[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hDEAD_BEEF, 32'h0,        0, 0, 0, 0, 0, 32'h0,      1, 0, 32'hDEAD_BEEF, 0, 0, 32'h0);
        tbl[7]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h1234_5678, 32'h0,        0, 0, 0, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 32'h0);
        tbl[8]  = mk(1, 0, 32'h800,      0, 0, 32'h0,        0, 32'h0,         32'h0,        1, 0, 0, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 32'h0);
        tbl[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h5555_5555, 32'h6666_6666, 0, 0, 0, 0, 0, 32'h0,     1, 1, 32'h0,         0, 0, 32'h0);
        tbl[10] = mk(1, 0, 32'h0,        1, 1, 32'h404,      1, 32'h0,         32'h0,        0, 1, 0, 1, 1, 32'h404,    0, 0, 32'h0,         0, 0, 32'h0);
        tbl[11] = mk(1, 0, 32'h0,        1, 1, 32'h408,      1, 32'h0,         32'h0,        0, 1, 0, 1, 1, 32'h408,    0, 0, 32'h0,         0, 0, 32'h0);
        tbl[12] = mk(1, 0, 32'h0,        1, 1, 32'h40C,      1, 32'h0,         32'h0,        0, 1, 0, 1, 1, 32'h40C,    0, 0, 32'h0,         0, 0, 32'h0);
        tbl[13] = mk(1, 0, 32'h0,        1, 1, 32'h410,      1, 32'h0,         32'h0,        0, 1, 0, 1, 1, 32'h410,    0, 0, 32'h0,         0, 0, 32'h0);
        tbl[14] = mk(1, 0, 32'h0,        1, 1, 32'h414,      0, 32'h0,         32'h0,        1, 0, 1, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 32'h0);
        tbl[15] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h77,        32'h0,        0, 0, 0, 0, 0, 32'h0,      1, 0, 32'h77,        0, 0, 32'h0);
        tbl[16] = mk(0, 0, 32'h0,        1, 1, 32'hFFFF_0000, 0, 32'h0,        32'h0,        0, 1, 0, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 32'h0);
        tbl[17] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h1,         32'h2,        0, 0, 0, 0, 0, 32'h0,      0, 0, 32'h0,         0, 1, 32'h0);
        tbl[18] = mk(0, 0, 32'h0,        1, 0, 32'h408,      0, 32'h0,         32'h0,        0, 1, 0, 1, 0, 32'h408,    0, 0, 32'h0,         0, 0, 32'h0);
        tbl[19] = mk(1, 0, 32'h20,       0, 0, 32'h0,        0, 32'h11,        32'h99,       1, 0, 1, 0, 0, 32'h20,     0, 0, 32'h0,         1, 0, 32'h99);
        tbl[20] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h42,        32'h99,       0, 0, 0, 0, 0, 32'h0,      1, 0, 32'h42,        0, 0, 32'h0);
        tbl[21] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,         32'h0,        0, 1, 1, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 32'h0);
        tbl[22] = mk(1, 0, 32'h4,        0, 0, 32'h0,        1, 32'h31,        32'h0,        0, 0, 0, 0, 0, 32'h0,      0, 0, 32'h0,         1, 0, 32'h31);
        tbl[23] = mk(1, 0, 32'h4,        0, 0, 32'h0,        0, 32'h0,         32'h0,        1, 0, 1, 0, 0, 32'h4,      0, 0, 32'h0,         0, 0, 32'h0);
        tbl[24] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h55,        32'h0,        0, 0, 0, 0, 0, 32'h0,      1, 0, 32'h55,        0, 0, 32'h0);

        // in reset with both masters requesting: nothing granted, all outputs idle
        m0_req = 1; m1_req = 1; m1_addr = 32'h4; ram_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("reset_idle", '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), expect_of(tbl[i]));
        end

        // read granted, then reset before its response: the response is dropped
        @(posedge clk); #1;
        drive(mk(1, 0, 32'h10, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1, 0, 1, 0, 0, 32'h10, 0, 0, 32'h0, 0, 0, 32'h0));
        @(negedge clk);
        check("rst_seq_grant", expect_of(mk(1, 0, 32'h10, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1, 0, 1, 0, 0, 32'h10, 0, 0, 32'h0, 0, 0, 32'h0)));
        @(posedge clk); #1;
        rstn = 1'b0;
        drive(mk(1, 0, 32'h0, 1, 0, 32'h4, 0, 32'hBAD0_0BAD, 32'hBAD1_1BAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("rst_seq_in_reset", '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        // last grant before reset was M0, so M0 winning this tie proves rr_last reset
        v = mk(1, 0, 32'h0, 1, 0, 32'h4, 0, 32'hBAD0_0BAD, 32'h0, 1, 0, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        drive(v);
        @(negedge clk);
        check("rst_seq_release", expect_of(v));
        @(posedge clk); #1;
        v = mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h6060_6060, 32'h0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h6060_6060, 0, 0, 32'h0);
        drive(v);
        @(negedge clk);
        check("rst_seq_resp", expect_of(v));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
